// File: rtl/ntt_twiddle_sequencer_if.sv
// Operand bus between the twiddle sequencer and the butterfly datapath.
// The master side drives the decoded ROM fields and op_valid.
// The slave side returns op_ready.
interface ntt_twiddle_sequencer_if;
    logic        op_valid;
    logic        op_ready;
    logic [11:0] op_zeta;
    logic [7:0]  op_addr_a;
    logic [7:0]  op_addr_b;
    logic [15:0] op_cfg;
    logic [7:0]  op_step;
    logic [7:0]  op_tag;

    modport master (
        output op_valid, op_zeta, op_addr_a, op_addr_b, op_cfg, op_step, op_tag,
        input  op_ready
    );

    modport slave (
        input  op_valid, op_zeta, op_addr_a, op_addr_b, op_cfg, op_step, op_tag,
        output op_ready
    );
endinterface

// File: rtl/ntt_twiddle_sequencer.sv
// NTT twiddle sequencer.
// Walks the 128-entry control/twiddle ROM upward (dir=0) or downward (dir=1).
// Each word is decoded into butterfly operand fields and handed to the datapath
// over a valid/ready bus.
// A 2-entry buffer plus a credit rule guarantee that no issued ROM read is lost.
// Optional word checker: define NTT_SEQ_CHECK_EN; otherwise err is tied low.
module ntt_twiddle_sequencer #(
    parameter int ADDR_W      = 7,
    parameter int NUM_ENTRIES = 128,
    parameter int Q           = 3329
) (
    input  logic                    clk,
    input  logic                    srst,
    input  logic                    start,
    input  logic                    dir,
    output logic [ADDR_W-1:0]       rom_addr,
    output logic                    rom_srst,
    input  logic [63:0]             rom_dout,
    ntt_twiddle_sequencer_if.master op,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_ENTRIES - 1);
    localparam logic [ADDR_W-1:0] ONE_ADDR  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   NUM_CNT   = (ADDR_W + 1)'(NUM_ENTRIES);
    localparam logic [ADDR_W:0]   LAST_CNT  = (ADDR_W + 1)'(NUM_ENTRIES - 1);
    localparam logic [ADDR_W:0]   ONE_CNT   = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] rom_addr_reg;
    logic [ADDR_W:0]   issue_cnt_reg;
    logic              dir_reg;
    logic              in_flight_reg;
    logic [1:0]        occ_reg;
    logic [59:0]       slot_reg [2];

    logic       start_pass, issue, last_issue, push, pop, op_valid_int, wr_idx;
    logic [2:0] credit_used, credit_limit;
    logic       unused_rom_bits;

    // Bits [63:60] carry no field
    assign unused_rom_bits = ^rom_dout[63:60];

    assign rom_addr     = rom_addr_reg;
    assign rom_srst     = 1'b0;
    assign op_valid_int = (occ_reg != 2'd0);
    assign start_pass   = (state_reg == IDLE) && start;
    assign push         = in_flight_reg;
    assign pop          = op_valid_int && op.op_ready;

    // A slot freed by a same-cycle pop counts as available credit.
    // This keeps one op per clock while the buffer still cannot overflow.
    assign credit_used  = {1'b0, occ_reg} + {2'b00, in_flight_reg};
    assign credit_limit = 3'd2 + {2'b00, pop};
    assign issue        = (state_reg == FETCH) && (issue_cnt_reg < NUM_CNT) &&
                          (credit_used < credit_limit);
    assign last_issue   = issue && (issue_cnt_reg == LAST_CNT);

    // A push lands behind the surviving entries: slot 1 only if one stays.
    assign wr_idx = occ_reg[1] | (occ_reg[0] & ~pop);

    // The buffer head is the operand register set seen by the datapath
    assign op.op_valid  = op_valid_int;
    assign op.op_zeta   = slot_reg[0][59:48];
    assign op.op_addr_a = slot_reg[0][47:40];
    assign op.op_addr_b = slot_reg[0][39:32];
    assign op.op_cfg    = slot_reg[0][31:16];
    assign op.op_step   = slot_reg[0][15:8];
    assign op.op_tag    = slot_reg[0][7:0];

    // Address walk: load the start address on start and step on every issue.
    // Stepping stops after the final issue, so the address never wraps.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            rom_addr_reg  <= '0;
            issue_cnt_reg <= '0;
            dir_reg       <= 1'b0;
        end else if (start_pass) begin
            rom_addr_reg  <= dir ? LAST_ADDR : '0;
            issue_cnt_reg <= '0;
            dir_reg       <= dir;
        end else if (issue) begin
            issue_cnt_reg <= issue_cnt_reg + ONE_CNT;
            if (!last_issue) begin
                rom_addr_reg <= dir_reg ? (rom_addr_reg - ONE_ADDR) : (rom_addr_reg + ONE_ADDR);
            end
        end
    end

    // The in-flight flag marks a ROM word that arrives on the next cycle
    always_ff @(posedge clk or posedge srst) begin
        if (srst) in_flight_reg <= 1'b0;
        else      in_flight_reg <= issue;
    end

    // Buffer occupancy: push and pop in the same cycle cancel out
    always_ff @(posedge clk or posedge srst) begin
        if (srst) occ_reg <= 2'd0;
        else      occ_reg <= occ_reg + {1'b0, push} - {1'b0, pop};
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
        // Slot storage: load at the write position, or shift toward the head on pop
        always_ff @(posedge clk or posedge srst) begin
            if (srst) begin
                slot_reg[gi] <= '0;
            end else if (push && (wr_idx == 1'(gi))) begin
                slot_reg[gi] <= rom_dout[59:0];
            end else if (pop && (gi == 0)) begin
                slot_reg[gi] <= slot_reg[1];
            end
        end
    end

`ifdef NTT_SEQ_CHECK_EN
    logic [ADDR_W-1:0] inflight_addr_reg;
    logic              chk_bad;
    logic              err_reg;

    assign chk_bad = (rom_dout[59:48] >= 12'(Q)) ||
                     (rom_dout[6:0] != 7'(inflight_addr_reg)) ||
                     !rom_dout[7];
    assign err = err_reg;

    // Remember which entry is in flight so its tag can be checked on arrival
    always_ff @(posedge clk or posedge srst) begin
        if (srst)       inflight_addr_reg <= '0;
        else if (issue) inflight_addr_reg <= rom_addr_reg;
    end

    // Sticky error flag: set by a bad word at push time, cleared by a new pass
    always_ff @(posedge clk or posedge srst) begin
        if (srst)                 err_reg <= 1'b0;
        else if (start_pass)      err_reg <= 1'b0;
        else if (push && chk_bad) err_reg <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or posedge srst) begin
        if (srst) state_reg <= IDLE;
        else      state_reg <= state_next;
    end

    // FSM next state.
    // DRAIN ends when the buffer empties this cycle with nothing in flight.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = FETCH;
            FETCH:   if (last_issue) state_next = DRAIN;
            DRAIN:   if (!in_flight_reg && ((occ_reg == 2'd0) || ((occ_reg == 2'd1) && pop)))
                         state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state_reg != IDLE);
        done = (state_reg == DONE);
    end
endmodule

// File: tb/tb_ntt_twiddle_sequencer.sv
// Self-checking bench for ntt_twiddle_sequencer.
// A behavioural registered ROM feeds the DUT.
// Expected operand words go into a queue when a pass starts.
// They are popped as the DUT transfers them.
module tb_ntt_twiddle_sequencer;
    localparam int N = 128;
`ifdef NTT_SEQ_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        srst, start, dir;
    logic [6:0]  rom_addr;
    logic        rom_srst;
    logic [63:0] rom_dout;
    logic        busy, done, err;
    logic [59:0] obs_fields;

    ntt_twiddle_sequencer_if op_bus();

    ntt_twiddle_sequencer #(.ADDR_W(7), .NUM_ENTRIES(N), .Q(3329)) dut (
        .clk      (clk),
        .srst     (srst),
        .start    (start),
        .dir      (dir),
        .rom_addr (rom_addr),
        .rom_srst (rom_srst),
        .rom_dout (rom_dout),
        .op       (op_bus),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    assign obs_fields = {op_bus.op_zeta, op_bus.op_addr_a, op_bus.op_addr_b,
                         op_bus.op_cfg, op_bus.op_step, op_bus.op_tag};

    // Behavioural ROM with one cycle of registered read latency
    logic [63:0] rom_mem [N];
    always @(posedge clk) rom_dout <= rom_mem[rom_addr];

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int ready_mode = 0;
    bit mon_en = 0;
    int xfer_count, done_count, first_valid_cyc, first_xfer_cyc, last_xfer_cyc, done_cyc;
    logic [59:0] exp_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [63:0] make_word(input int i);
        logic [11:0] z;
        logic [7:0]  a, b, st, tg;
        logic [15:0] cf;
        z  = 12'((i * 37 + 11) % 3329);
        a  = 8'(2 * i);
        b  = 8'(2 * i + 2);
        cf = 16'(16'h0a0b + i);
        st = 8'(i / 2);
        tg = 8'(8'h80 | i);
        if (i == 0) z = 12'h6a5;
        if (i == N - 1) begin
            z = 12'h44f;
            a = 8'hfd;
            b = 8'hff;
        end
        return {4'h0, z, a, b, cf, st, tg};
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Ready generator: held high, or random with occasional 10-cycle stalls
    initial begin
        int stall;
        stall = 0;
        op_bus.op_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 0) begin
                op_bus.op_ready = 1'b1;
            end else if (stall > 0) begin
                op_bus.op_ready = 1'b0;
                stall--;
            end else if ($urandom_range(0, 24) == 0) begin
                op_bus.op_ready = 1'b0;
                stall = 9;
            end else begin
                op_bus.op_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    // Monitor.
    // Every valid cycle must present the scoreboard head, which also covers
    // stability during stalls.
    initial forever begin
        @(negedge clk);
        if (!srst && mon_en) begin
            if (op_bus.op_valid) begin
                if (exp_q.size() == 0) begin
                    check("op_extra", op_bus.op_valid, 1'b0);
                end else begin
                    check("op_fields", obs_fields, exp_q[0]);
                    if (first_valid_cyc < 0) first_valid_cyc = cyc;
                    if (op_bus.op_ready) begin
                        void'(exp_q.pop_front());
                        if (xfer_count == 0) first_xfer_cyc = cyc;
                        xfer_count++;
                        last_xfer_cyc = cyc;
                    end
                end
            end
            if (done) begin
                done_count++;
                done_cyc = cyc;
            end
        end
    end

    task automatic launch(input logic d, output int sc);
        exp_q.delete();
        for (int k = 0; k < N; k++) begin
            logic [63:0] w;
            w = rom_mem[d ? (N - 1 - k) : k];
            exp_q.push_back(w[59:0]);
        end
        xfer_count      = 0;
        done_count      = 0;
        first_valid_cyc = -1;
        first_xfer_cyc  = -1;
        last_xfer_cyc   = -1;
        done_cyc        = -1;
        mon_en          = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b1;
        dir   = d;
        @(posedge clk);
        #1;
        start = 1'b0;
        sc    = cyc;
    endtask

    task automatic run_pass(input logic d, input int mode, input int restart_at, input logic exp_err);
        int  sc;
        bit  pulsed;
        logic [6:0] exp_last;
        ready_mode = mode;
        launch(d, sc);
        check("busy_at_start", busy, 1'b1);
        check("err_cleared_by_start", err, 1'b0);
        pulsed = 0;
        for (int t = 0; t < 4000 && done_count == 0; t++) begin
            @(negedge clk);
            #1;
            start = 1'b0;
            if (t == 5) dir = ~d;
            if (restart_at >= 0 && !pulsed && xfer_count >= restart_at) begin
                start  = 1'b1;
                pulsed = 1;
            end
        end
        start = 1'b0;
        check("done_seen", done_count, 1);
        check("done_pulse_level", done, 1'b1);
        check("busy_with_done", busy, 1'b1);
        @(negedge clk);
        #1;
        check("busy_after_done", busy, 1'b0);
        check("done_one_cycle", done, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        exp_last = d ? 7'd0 : 7'd127;
        check("single_done", done_count, 1);
        check("op_count", xfer_count, N);
        check("queue_empty", exp_q.size(), 0);
        check("first_valid_latency", first_valid_cyc, sc + 2);
        check("done_after_last", done_cyc, last_xfer_cyc + 1);
        check("rom_addr_halt", rom_addr, exp_last);
        check("rom_srst", rom_srst, 1'b0);
        check("err_end", err, exp_err);
        if (mode == 0) check("throughput", last_xfer_cyc - first_xfer_cyc, N - 1);
        $display("[TB] pass dir=%0d ready_mode=%0d restart_at=%0d ops=%0d dones=%0d err=%0d",
                 d, mode, restart_at, xfer_count, done_count, err);
    endtask

    initial begin
        int sc;
        for (int i = 0; i < N; i++) rom_mem[i] = make_word(i);
        srst  = 1'b1;
        start = 1'b0;
        dir   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", op_bus.op_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_addr", rom_addr, 7'd0);
        check("rst_fields", obs_fields, 60'd0);
        srst = 1'b0;
        repeat (2) @(negedge clk);

        run_pass(1'b0, 0, -1, 1'b0);
        run_pass(1'b1, 0, -1, 1'b0);
        run_pass(1'b0, 1, -1, 1'b0);
        run_pass(1'b1, 1, 50, 1'b0);

        // Asynchronous reset in the middle of a pass, with an op on the bus
        ready_mode = 0;
        launch(1'b0, sc);
        for (int t = 0; t < 1000 && xfer_count < 64; t++) begin
            @(negedge clk);
            #1;
        end
        check("mid_pass_count", xfer_count, 64);
        check("mid_pass_valid", op_bus.op_valid, 1'b1);
        #2;
        srst = 1'b1;
        #1;
        check("async_rst_valid", op_bus.op_valid, 1'b0);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_fields", obs_fields, 60'd0);
        check("async_rst_addr", rom_addr, 7'd0);
        exp_q.delete();
        @(negedge clk);
        #1;
        srst = 1'b0;
        $display("[TB] reset at op %0d", xfer_count);
        run_pass(1'b0, 0, -1, 1'b0);

        // Corrupted zeta on entry 5: flagged only when the checker is built in
        rom_mem[5][59:48] = 12'hd01;
        run_pass(1'b0, 0, -1, EXP_ERR);
        repeat (4) @(negedge clk);
        check("err_sticky", err, EXP_ERR);
        rom_mem[5] = make_word(5);
        run_pass(1'b0, 1, -1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
